// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin index arbiter.
// Provides the default requester count, FSM state type and pointer wrap.
package arb_pkg;

    localparam int ARB_N_DEFAULT = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    // Next pointer after idx, wrapping at n-1 (n need not be a power of two).
    function automatic int unsigned wrap_inc(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around first-set search: lowest set req bit at or above start,
// else lowest set bit overall. Ports: req, start -> found, idx.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic             any_found;
    logic [IDX_W-1:0] any_idx;

    // Descending scans leave the lowest qualifying index in place.
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        any_found = 1'b0;
        any_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_found = 1'b1;
                any_idx   = IDX_W'(i);
                if (IDX_W'(i) >= start) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign found = any_found;
    assign idx   = hi_found ? hi_idx : any_idx;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter producing a registered grant index and valid strobe,
// held under a valid/ready handshake; feeds a one-hot decoder (in/en).
// Ports: clk, rst_n (sync, active-low), req[N], gnt_ready -> gnt_valid, gnt_idx.
// Optional macro RR_ARB_FIXED_PRIO_EN adds prio_fixed: search from 0,
// pointer frozen while it is high.
module rr_index_arbiter
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             gnt_ready,
`ifdef RR_ARB_FIXED_PRIO_EN
    input  logic             prio_fixed,
`endif
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic             fixed;
    logic             hs;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

`ifdef RR_ARB_FIXED_PRIO_EN
    assign fixed = prio_fixed;
`else
    assign fixed = 1'b0;
`endif

    assign hs      = (state_q == GRANT) && gnt_ready;
    assign ptr_nxt = IDX_W'(wrap_inc(32'(gnt_idx_q), 32'(N)));

    // On a handshake re-arbitrate from the advanced pointer in the same edge.
    always_comb begin
        start = ptr_q;
        if (fixed) begin
            start = '0;
        end else if (hs) begin
            start = ptr_nxt;
        end
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    if (!fixed) begin
                        ptr_d = ptr_nxt;
                    end
                    if (pick_found) begin
                        gnt_idx_d = pick_idx;
                    end else begin
                        gnt_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: directed vector table, hand sequences,
// and randomized traffic against a behavioural model (N=8 and N=5).
module tb_rr_index_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req8;
    logic       rdy8;
    logic       fx8;
    logic       valid8;
    logic [2:0] idx8;
    logic [4:0] req5;
    logic       rdy5;
    logic       fx5;
    logic       valid5;
    logic [2:0] idx5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_index_arbiter #(.N(8)) u8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req8),
        .gnt_ready  (rdy8),
`ifdef RR_ARB_FIXED_PRIO_EN
        .prio_fixed (fx8),
`endif
        .gnt_valid  (valid8),
        .gnt_idx    (idx8)
    );

    rr_index_arbiter #(.N(5)) u5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req5),
        .gnt_ready  (rdy5),
`ifdef RR_ARB_FIXED_PRIO_EN
        .prio_fixed (fx5),
`endif
        .gnt_valid  (valid5),
        .gnt_idx    (idx5)
    );

    // Behavioural model state, index 0 = N=8 instance, 1 = N=5 instance.
    int m_valid [2];
    int m_idx   [2];
    int m_ptr   [2];
    int m_n     [2] = '{8, 5};

    function automatic int first_from(input logic [7:0] r, input int s, input int n);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (s + k) % n;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic [7:0] r, input logic rdy, input logic fx);
        int n;
        int w;
        int np;
        logic f;
        n = m_n[d];
`ifdef RR_ARB_FIXED_PRIO_EN
        f = fx;
`else
        f = 1'b0;
        if (fx) f = 1'b0;
`endif
        if (!rst_n) begin
            m_valid[d] = 0;
            m_idx[d]   = 0;
            m_ptr[d]   = 0;
        end else if (m_valid[d] == 0) begin
            w = first_from(r, f ? 0 : m_ptr[d], n);
            if (w >= 0) begin
                m_idx[d]   = w;
                m_valid[d] = 1;
            end
        end else if (rdy) begin
            np = (m_idx[d] + 1) % n;
            if (!f) m_ptr[d] = np;
            w = first_from(r, f ? 0 : np, n);
            if (w >= 0) m_idx[d] = w;
            else m_valid[d] = 0;
        end
    endtask

    task automatic tick();
        model_step(0, req8, rdy8, fx8);
        model_step(1, {3'b000, req5}, rdy5, fx5);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [2:0] ei;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [7:0] r, input logic rd,
                                input logic ev, input logic [2:0] ei,
                                input string nm);
        vec_t v;
        v.req = r;
        v.rdy = rd;
        v.ev  = ev;
        v.ei  = ei;
        v.nm  = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0;
        req8  = 8'hFF;
        rdy8  = 1'b0;
        fx8   = 1'b0;
        req5  = '0;
        rdy5  = 1'b0;
        fx5   = 1'b0;
        #1;

        // Reset held for two cycles with all requests high.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", valid8, 0);
            check("rst_idx", idx8, 0);
        end
        rst_n = 1'b1;
        tick();
        check("rel_valid", valid8, 1);
        check("rel_idx", idx8, 0);

        for (int i = 1; i <= 8; i++) add(8'hFF, 1'b1, 1'b1, 3'(i % 8), "rotate");
        add(8'b0010_0100, 1'b1, 1'b1, 3'd2, "bp_first");
        for (int i = 0; i < 5; i++) add(8'b0010_0100, 1'b0, 1'b1, 3'd2, "bp_hold");
        add(8'b0010_0100, 1'b1, 1'b1, 3'd5, "bp_next");
        add(8'b0010_0100, 1'b1, 1'b1, 3'd2, "bp_wrap");
        add(8'b0100_0000, 1'b1, 1'b1, 3'd6, "to_six");
        add(8'b0000_0011, 1'b1, 1'b1, 3'd0, "wrap0");
        add(8'b0000_0011, 1'b1, 1'b1, 3'd1, "wrap1");
        add(8'b0000_1000, 1'b1, 1'b1, 3'd3, "to_three");
        add(8'b0000_0000, 1'b0, 1'b1, 3'd3, "withdraw_hold");
        add(8'b0000_0000, 1'b1, 1'b0, 3'd3, "to_idle");
        add(8'b0000_0000, 1'b1, 1'b0, 3'd3, "idle_rdy");
        add(8'b1000_0000, 1'b0, 1'b1, 3'd7, "idle_pick");

        foreach (vecs[i]) begin
            req8 = vecs[i].req;
            rdy8 = vecs[i].rdy;
            tick();
            check({vecs[i].nm, "_valid"}, valid8, int'(vecs[i].ev));
            check({vecs[i].nm, "_idx"}, idx8, int'(vecs[i].ei));
        end

        // Reset while a grant is outstanding drops it.
        req8  = 8'h00;
        rdy8  = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_valid", valid8, 0);
        check("midrst_idx", idx8, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", valid8, 0);

        // N=5: grant to 4 then wrap back to 0.
        req5 = 5'b1_0001;
        tick();
        check("n5_first", idx5, 0);
        check("n5_first_v", valid5, 1);
        rdy5 = 1'b1;
        tick();
        check("n5_four", idx5, 4);
        tick();
        check("n5_wrap", idx5, 0);
        rdy5 = 1'b0;

`ifdef RR_ARB_FIXED_PRIO_EN
        fx5  = 1'b1;
        rdy5 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fixed_zero", idx5, 0);
        end
        fx5  = 1'b0;
        rdy5 = 1'b0;
`endif

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            req8  = 8'($urandom) & 8'($urandom);
            req5  = 5'($urandom) & 5'($urandom);
            rdy8  = ($urandom_range(0, 3) != 0);
            rdy5  = ($urandom_range(0, 2) != 0);
`ifdef RR_ARB_FIXED_PRIO_EN
            fx8   = ($urandom_range(0, 7) == 0);
            fx5   = ($urandom_range(0, 7) == 0);
`endif
            tick();
            check("rnd8_valid", valid8, m_valid[0]);
            if (m_valid[0] != 0) check("rnd8_idx", idx8, m_idx[0]);
            check("rnd5_valid", valid5, m_valid[1]);
            if (m_valid[1] != 0) check("rnd5_idx", idx5, m_idx[1]);
            check("rnd5_range", int'(idx5 <= 3'd4), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 3-to-8 one-hot decoder.
- Selects one of N requesters and produces a binary grant index (gnt_idx) plus a valid strobe (gnt_valid); these drive the decoder's `in` and `en` inputs.
- Grant is registered and held under a valid/ready handshake, so the downstream one-hot select stays stable until it is consumed.
- Fairness: rotating priority pointer, one grant per handshake.

Parameters:
- N, 8, number of requesters; N >= 2; need not be a power of two.
- IDX_W, $clog2(N), width of the grant index. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req  input  N  request vector; bit i = requester i wants a grant; level-sensitive.
- gnt_ready  input  1  downstream accepts the current grant this cycle.
- gnt_valid  output  1  gnt_idx holds a valid grant; drives decoder enable.
- gnt_idx  output  IDX_W  index of the granted requester; drives decoder select.

Behaviour:
- Reset (rst_n low at a clk edge):
  - gnt_valid=0, gnt_idx=0, pointer ptr=0, state=IDLE.
  - Reset mid-grant drops the outstanding grant without a handshake.
- Winner selection:
  - Winner is the first set bit of req, searching upward from ptr and wrapping from N-1 to 0.
  - If ptr holds req bit set, ptr itself wins.
- IDLE state:
  - gnt_valid=0.
  - If |req at edge t: register the winner into gnt_idx, set gnt_valid=1 at t+1, go to GRANT.
  - If req==0: remain in IDLE.
- GRANT state:
  - gnt_valid=1; gnt_idx is stable and req is ignored while gnt_ready=0.
  - On handshake (gnt_valid & gnt_ready) at edge t:
    - ptr <= (gnt_idx==N-1) ? 0 : gnt_idx+1.
    - Re-arbitrate in the same edge using that new ptr (computed combinationally) against the current req.
    - If a winner exists: load it into gnt_idx, keep gnt_valid=1, stay in GRANT. This gives back-to-back grants at one per cycle.
    - If no winner: gnt_valid=0 at t+1, go to IDLE. gnt_idx holds its last value.
- Request withdrawal: if the granted requester drops req while in GRANT, the grant is not withdrawn. It completes on the next handshake.
- gnt_ready while gnt_valid=0 is ignored; ptr does not move.
- Latency: 1 cycle from req sampled to gnt_valid.
- Throughput: 1 grant per cycle while gnt_ready=1 and requests remain.
- Fairness: with all N bits held high and gnt_ready=1, grants cycle 0,1,...,N-1,0.
- Non-power-of-two N: gnt_idx never exceeds N-1. The pointer wrap uses N-1, not 2^IDX_W-1.
- gnt_idx is a flop output; no combinational path from req or gnt_ready to either output.

Optional Feature:
- Macro: RR_ARB_FIXED_PRIO_EN.
- Defined:
  - Adds input port prio_fixed (1 bit).
  - While prio_fixed=1, the search starts at index 0 instead of ptr, and ptr is not updated on handshake.
  - prio_fixed=0 restores round-robin from the frozen ptr.
- Undefined: no prio_fixed port; round-robin only.

Decomposition:
- Package arb_pkg:
  - ARB_N_DEFAULT=8.
  - Function for the wrap increment.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- One sub-module: rr_pick. Purely combinational; inputs req, start index; outputs found, idx. Implements the wrap-around first-set search and is instantiated once.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=8'hFF -> gnt_valid=0, gnt_idx=0 throughout; release -> gnt_valid=1, gnt_idx=0 one cycle later.
- Rotation: req=8'hFF, gnt_ready=1 constant -> gnt_idx sequence 0,1,2,...,7,0 on consecutive cycles, gnt_valid never drops.
- Backpressure: req=8'b0010_0100, gnt_ready=0 for 5 cycles -> gnt_idx=2 held stable; gnt_ready=1 one cycle -> next gnt_idx=5; ready again -> gnt_idx=2.
- Wrap/skip: after a grant to 6, req=8'b0000_0011 -> next gnt_idx=0, then 1.
- Withdrawal and idle: grant to 3 outstanding, req drops to 0 -> gnt_idx=3 still valid; handshake -> gnt_valid=0 next cycle, gnt_idx stays 3.
- N=5 build: req=5'b1_0001, grant to 4 then handshake -> next gnt_idx=0; gnt_idx never reaches 5-7. With RR_ARB_FIXED_PRIO_EN and prio_fixed=1 -> index 0 always wins.
